// File: rtl/operand_read_pkg.sv
// Shared types and default widths for the operand-read stage.
// The FSM state encoding is kept here so the stage and any tooling agree on it.
package operand_read_pkg;

    localparam int CONTROL_WIDTH   = 21;
    localparam int R_DATA_WIDTH    = 32;
    localparam int NUM_WARPS       = 4;
    localparam int REGS_PER_THREAD = 16;

    typedef enum logic [1:0] {
        IDLE,
        RD1,
        RD2,
        OUT
    } state_t;

endpackage

// File: rtl/operand_read_if.sv
// Decode, write-back and execute signals of the operand-read stage.
// The stage itself connects through the slave modport; its driver uses master.
interface operand_read_if #(
    parameter int CONTROL_WIDTH   = operand_read_pkg::CONTROL_WIDTH,
    parameter int R_DATA_WIDTH    = operand_read_pkg::R_DATA_WIDTH,
    parameter int NUM_WARPS       = operand_read_pkg::NUM_WARPS,
    parameter int REGS_PER_THREAD = operand_read_pkg::REGS_PER_THREAD,
    parameter int WARP_DEPTH      = $clog2(NUM_WARPS),
    parameter int REG_DEPTH       = $clog2(REGS_PER_THREAD)
) ();

    logic                     valid_d;
    logic                     ready_d;
    logic [CONTROL_WIDTH-1:0] control_d;
    logic [WARP_DEPTH-1:0]    warp_d;
    logic [REG_DEPTH-1:0]     src1_d;
    logic [REG_DEPTH-1:0]     src2_d;

    logic [R_DATA_WIDTH-1:0]  rdata_wb;
    logic                     rwe_wb;
    logic [WARP_DEPTH-1:0]    warp_wb;
    logic [REG_DEPTH-1:0]     dst_wb;

    logic                     valid_r;
    logic                     ready_r;
    logic [CONTROL_WIDTH-1:0] control_r;
    logic [R_DATA_WIDTH-1:0]  src1_data_r;
    logic [R_DATA_WIDTH-1:0]  src2_data_r;

    modport slave (
        input  valid_d, control_d, warp_d, src1_d, src2_d,
        input  rdata_wb, rwe_wb, warp_wb, dst_wb,
        input  ready_r,
        output ready_d, valid_r, control_r, src1_data_r, src2_data_r
    );

    modport master (
        output valid_d, control_d, warp_d, src1_d, src2_d,
        output rdata_wb, rwe_wb, warp_wb, dst_wb,
        output ready_r,
        input  ready_d, valid_r, control_r, src1_data_r, src2_data_r
    );

endinterface

// File: rtl/operand_read_reg_array.sv
// Per-warp register storage: one write port, one combinational read port.
// A read of the address being written this cycle returns the write data.
module operand_read_reg_array #(
    parameter int R_DATA_WIDTH    = operand_read_pkg::R_DATA_WIDTH,
    parameter int NUM_WARPS       = operand_read_pkg::NUM_WARPS,
    parameter int REGS_PER_THREAD = operand_read_pkg::REGS_PER_THREAD,
    parameter int WARP_DEPTH      = $clog2(NUM_WARPS),
    parameter int REG_DEPTH       = $clog2(REGS_PER_THREAD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [WARP_DEPTH-1:0]   wwarp,
    input  logic [REG_DEPTH-1:0]    waddr,
    input  logic [R_DATA_WIDTH-1:0] wdata,
    input  logic [WARP_DEPTH-1:0]   rwarp,
    input  logic [REG_DEPTH-1:0]    raddr,
    output logic [R_DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = NUM_WARPS * REGS_PER_THREAD;

    logic [R_DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: every entry must read zero after reset, so the array is a bank of
    // async-cleared flops rather than an inferred RAM (RAMs cannot be reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[{wwarp, waddr}] <= wdata;
        end
    end

    always_comb begin
        if (we && ({wwarp, waddr} == {rwarp, raddr})) begin
            rdata = wdata;
        end else begin
            rdata = mem[{rwarp, raddr}];
        end
    end

endmodule

// File: rtl/operand_read.sv
// Operand-fetch stage: accepts a decoded instruction, reads both sources over
// two cycles through one read port, and holds the result toward execution.
module operand_read #(
    parameter int CONTROL_WIDTH   = operand_read_pkg::CONTROL_WIDTH,
    parameter int R_DATA_WIDTH    = operand_read_pkg::R_DATA_WIDTH,
    parameter int NUM_WARPS       = operand_read_pkg::NUM_WARPS,
    parameter int REGS_PER_THREAD = operand_read_pkg::REGS_PER_THREAD,
    parameter int WARP_DEPTH      = $clog2(NUM_WARPS),
    parameter int REG_DEPTH       = $clog2(REGS_PER_THREAD)
) (
    input logic           clk,
    input logic           rst,
    operand_read_if.slave bus
);

    import operand_read_pkg::*;

    state_t                   state;
    logic [WARP_DEPTH-1:0]    warp_q;
    logic [REG_DEPTH-1:0]     src1_q;
    logic [REG_DEPTH-1:0]     src2_q;
    logic [CONTROL_WIDTH-1:0] control_q;
    logic [R_DATA_WIDTH-1:0]  src1_data_q;
    logic [R_DATA_WIDTH-1:0]  src2_data_q;
    logic                     valid_q;

    logic                     ready_d;
    logic                     accept;
    logic                     hit1;
    logic                     hit2;
    logic [REG_DEPTH-1:0]     rd_addr;
    logic [R_DATA_WIDTH-1:0]  rd_data;

    operand_read_reg_array #(
        .R_DATA_WIDTH   (R_DATA_WIDTH),
        .NUM_WARPS      (NUM_WARPS),
        .REGS_PER_THREAD(REGS_PER_THREAD),
        .WARP_DEPTH     (WARP_DEPTH),
        .REG_DEPTH      (REG_DEPTH)
    ) u_reg_array (
        .clk  (clk),
        .rst  (rst),
        .we   (bus.rwe_wb),
        .wwarp(bus.warp_wb),
        .waddr(bus.dst_wb),
        .wdata(bus.rdata_wb),
        .rwarp(warp_q),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        ready_d = 1'b0;
        case (state)
            IDLE:    ready_d = 1'b1;
            OUT:     ready_d = bus.ready_r;
            default: ready_d = 1'b0;
        endcase
    end

    assign accept  = bus.valid_d && ready_d;
    assign rd_addr = (state == RD2) ? src2_q : src1_q;

    // Write-backs landing on a source already read must still reach the operand.
    assign hit1 = bus.rwe_wb && (bus.warp_wb == warp_q) && (bus.dst_wb == src1_q);
    assign hit2 = bus.rwe_wb && (bus.warp_wb == warp_q) && (bus.dst_wb == src2_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            warp_q      <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            control_q   <= '0;
            src1_data_q <= '0;
            src2_data_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            if (accept) begin
                warp_q    <= bus.warp_d;
                src1_q    <= bus.src1_d;
                src2_q    <= bus.src2_d;
                control_q <= bus.control_d;
            end
            case (state)
                IDLE: begin
                    if (bus.valid_d) state <= RD1;
                end
                RD1: begin
                    src1_data_q <= rd_data;
                    state       <= RD2;
                end
                RD2: begin
                    src2_data_q <= rd_data;
                    if (hit1) src1_data_q <= bus.rdata_wb;
                    valid_q     <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (hit1) src1_data_q <= bus.rdata_wb;
                    if (hit2) src2_data_q <= bus.rdata_wb;
                    if (bus.ready_r) begin
                        valid_q <= 1'b0;
                        state   <= bus.valid_d ? RD1 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready_d     = ready_d;
    assign bus.valid_r     = valid_q;
    assign bus.control_r   = control_q;
    assign bus.src1_data_r = src1_data_q;
    assign bus.src2_data_r = src2_data_q;

endmodule
